fetch_stage: RTL and testbench

//  IF stage of the WISC pipeline; sits directly upstream of memory_system's I-side.

---
 rtl/wisc_defs_pkg.sv | 13 +
 rtl/pc_reg.sv | 19 +
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/wisc_defs_pkg.sv
// Shared WISC definitions: opcodes, NOP encoding and fetch-stage state encoding.
package wisc_defs_pkg;

  localparam logic [3:0]  OP_HLT    = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MISS   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-high reset to RESET_PC, loads d when we is set.
module pc_reg #(
  parameter int          AWIDTH   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] d,
  output logic [AWIDTH-1:0] q
);

  // PC storage; holds its value whenever we is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= AWIDTH'(RESET_PC);
    else if (we) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// WISC IF stage: PC, IF/ID register, miss bubbles, freezes, ID redirects and HLT detection.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count and icache_stall_count outputs.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | fetching normally, one instruction per unfrozen cycle
// ST_MISS   | I-cache miss outstanding, PC held, IF/ID fed bubbles
// ST_HALTED | HLT fetched, PC frozen, bubbles only; exits on reset alone
module fetch_stage
  import wisc_defs_pkg::*;
#(
  parameter int          DWIDTH   = 16,
  parameter int          AWIDTH   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] instr_addr,
  input  logic [DWIDTH-1:0] instr_in,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  input  logic              hazard_stall,
  input  logic              branch_taken,
  input  logic [AWIDTH-1:0] branch_target,
  output logic [DWIDTH-1:0] ifid_instr,
  output logic [AWIDTH-1:0] ifid_pc_plus2,
  output logic              ifid_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       icache_stall_count,
`endif
  output logic              halted
);

  fetch_state_e      state;
  logic [AWIDTH-1:0] pc;
  logic [AWIDTH-1:0] pc_plus2;
  logic [AWIDTH-1:0] pc_next;
  logic              pc_we;
  logic              freeze;
  logic              is_halted;
  logic              do_redirect;
  logic              do_bubble;
  logic              do_fetch;
  logic              is_hlt;

  assign instr_addr = pc;
  assign pc_plus2   = pc + AWIDTH'(2);
  assign freeze     = dcache_stall | hazard_stall;
  assign is_halted  = (state == ST_HALTED);
  assign is_hlt     = (instr_in[DWIDTH-1 -: 4] == OP_HLT);

  // Resolve the per-cycle action in priority order: freeze, redirect, miss, fetch.
  always_comb begin
    do_redirect = 1'b0;
    do_bubble   = 1'b0;
    do_fetch    = 1'b0;
    pc_we       = 1'b0;
    pc_next     = pc;
    if (!freeze) begin
      if (is_halted) begin
        do_bubble = 1'b1;
      end else if (branch_taken) begin
        do_redirect = 1'b1;
        pc_we       = 1'b1;
        pc_next     = branch_target & ~AWIDTH'(1);
      end else if (icache_stall) begin
        do_bubble = 1'b1;
      end else begin
        do_fetch = 1'b1;
        // HLT stays at its own address so the PC freezes on it.
        if (!is_hlt) begin
          pc_we   = 1'b1;
          pc_next = pc_plus2;
        end
      end
    end
  end

  pc_reg #(
    .AWIDTH  (AWIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk(clk),
    .rst(rst),
    .we (pc_we),
    .d  (pc_next),
    .q  (pc)
  );

  // Fetch FSM together with the IF/ID register and the registered halted flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      halted        <= 1'b0;
      ifid_instr    <= DWIDTH'(NOP_INSTR);
      ifid_pc_plus2 <= '0;
      ifid_valid    <= 1'b0;
    end else if (do_redirect) begin
      state         <= ST_RUN;
      ifid_instr    <= DWIDTH'(NOP_INSTR);
      ifid_valid    <= 1'b0;
    end else if (do_bubble) begin
      if (!is_halted) state <= ST_MISS;
      ifid_instr    <= DWIDTH'(NOP_INSTR);
      ifid_valid    <= 1'b0;
    end else if (do_fetch) begin
      ifid_instr    <= instr_in;
      ifid_pc_plus2 <= pc_plus2;
      ifid_valid    <= 1'b1;
      if (is_hlt) begin
        state  <= ST_HALTED;
        halted <= 1'b1;
      end else begin
        state  <= ST_RUN;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic miss_cycle;
  assign miss_cycle = !freeze && !is_halted && ((state == ST_MISS) || icache_stall);

  // Saturating performance counters; neither moves once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count        <= '0;
      icache_stall_count <= '0;
    end else if (!is_halted) begin
      if (do_fetch && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (miss_cycle && (icache_stall_count != 32'hFFFF_FFFF))
        icache_stall_count <= icache_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] instr_addr;
  logic [15:0] instr_in;
  logic        icache_stall;
  logic        dcache_stall;
  logic        hazard_stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] icache_stall_count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .instr_addr   (instr_addr),
    .instr_in     (instr_in),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall),
    .hazard_stall (hazard_stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid   (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count       (fetch_count),
    .icache_stall_count(icache_stall_count),
`endif
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                        input logic [15:0] pcp2, input logic valid, input logic hlt);
    check({tag, ".addr"},  32'(instr_addr),    32'(addr));
    check({tag, ".instr"}, 32'(ifid_instr),    32'(instr));
    check({tag, ".pcp2"},  32'(ifid_pc_plus2), 32'(pcp2));
    check({tag, ".valid"}, 32'(ifid_valid),    32'(valid));
    check({tag, ".halt"},  32'(halted),        32'(hlt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_in = 16'h1234; icache_stall = 0; dcache_stall = 0;
    hazard_stall = 0; branch_taken = 0; branch_target = 16'h0000;

    // T1: reset state, then three hit fetches.
    do_reset();
    chk_if("t1_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_if("t1_f0", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);
    step(); chk_if("t1_f1", 16'h0004, 16'h1234, 16'h0004, 1'b1, 1'b0);
    step(); chk_if("t1_f2", 16'h0006, 16'h1234, 16'h0006, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("t1_fcnt", fetch_count, 32'd3);
`endif

    // Move to 0x0010 via redirect.
    branch_taken = 1; branch_target = 16'h0010;
    step(); branch_taken = 0;
    chk_if("t2_redir", 16'h0010, 16'h0000, 16'h0006, 1'b0, 1'b0);

    // T2: four miss cycles then the fetch at 0x0010.
    icache_stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_miss_addr",  32'(instr_addr), 32'h0010);
      check("t2_miss_valid", 32'(ifid_valid), 32'd0);
    end
`ifdef FETCH_PERF_CNT_EN
    check("t2_scnt", icache_stall_count, 32'd4);
`endif
    icache_stall = 0; instr_in = 16'h5A5A;
    step(); chk_if("t2_fetch", 16'h0012, 16'h5A5A, 16'h0012, 1'b1, 1'b0);

    // T3: redirect to odd target during a miss.
    icache_stall = 1;
    step();
    branch_taken = 1; branch_target = 16'h0101;
    step(); branch_taken = 0;
    chk_if("t3_redir", 16'h0100, 16'h0000, 16'h0012, 1'b0, 1'b0);
    icache_stall = 0; instr_in = 16'h1111;
    step(); chk_if("t3_fetch", 16'h0102, 16'h1111, 16'h0102, 1'b1, 1'b0);

    // T4: dcache freeze overrides a concurrent redirect for three cycles.
    dcache_stall = 1; branch_taken = 1; branch_target = 16'h0200; instr_in = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      step(); chk_if("t4_frz", 16'h0102, 16'h1111, 16'h0102, 1'b1, 1'b0);
    end
    dcache_stall = 0;
    step(); branch_taken = 0;
    chk_if("t4_redir", 16'h0200, 16'h0000, 16'h0102, 1'b0, 1'b0);
    hazard_stall = 1;
    step(); chk_if("t4_haz", 16'h0200, 16'h0000, 16'h0102, 1'b0, 1'b0);
    hazard_stall = 0;
    step(); chk_if("t4_fetch", 16'h0202, 16'h2222, 16'h0202, 1'b1, 1'b0);

    // T5: HLT at 0x0020.
    branch_taken = 1; branch_target = 16'h0020;
    step(); branch_taken = 0;
    instr_in = 16'hF000;
    step(); chk_if("t5_hlt", 16'h0020, 16'hF000, 16'h0022, 1'b1, 1'b1);
    instr_in = 16'h1234; branch_taken = 1; branch_target = 16'h0040;
    step(); chk_if("t5_ign", 16'h0020, 16'h0000, 16'h0022, 1'b0, 1'b1);
    step(); chk_if("t5_ign2", 16'h0020, 16'h0000, 16'h0022, 1'b0, 1'b1);
    branch_taken = 0;

    // T6: PC wrap, then asynchronous reset during a miss.
    do_reset();
    chk_if("t6_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    branch_taken = 1; branch_target = 16'hFFFE;
    step(); branch_taken = 0;
    check("t6_pc_fffe", 32'(instr_addr), 32'h0000FFFE);
    instr_in = 16'h3333;
    step(); chk_if("t6_wrap", 16'h0000, 16'h3333, 16'h0000, 1'b1, 1'b0);
    step(); chk_if("t6_f2", 16'h0002, 16'h3333, 16'h0002, 1'b1, 1'b0);
    icache_stall = 1;
    step();
    check("t6_miss_valid", 32'(ifid_valid), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_if("t6_async", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("t6_fcnt_rst", fetch_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0; icache_stall = 0;
    step(); chk_if("t6_after", 16'h0002, 16'h3333, 16'h0002, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
